// File: rtl/sd_sender.sv
// SPI-mode SD transmit serializer: frames a command (48 bits, CRC7) or a 512-byte data block (token, payload, CRC16) and shifts it out MSB-first on mosi.
// Latency: bit 0 is on mosi the cycle after acceptance; each bit advances one cycle after a bit_en strobe; ready returns the cycle after the last bit's strobe.
// Backpressure: ready is low for the whole frame and valid is ignored meanwhile; bit_en alone paces the serial stream, holding the current bit while low.
module sd_sender (
    input  logic          clock,
    input  logic          reset,
    input  logic          bit_en,
    input  logic          valid,
    output logic          ready,
    input  logic          send_data,
    input  logic [5:0]    cmd_index,
    input  logic [31:0]   argument,
    input  logic [4095:0] data,
    output logic          mosi,
    output logic          busy
);

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        SENDING_CMD  = 2'd1,
        SENDING_DATA = 2'd2
    } state_t;

    // Command frame layout: bits 0..39 covered by CRC7, 40..46 CRC7, 47 end bit.
    localparam logic [12:0] CMD_LAST_COVERED  = 13'd39;
    localparam logic [12:0] CMD_LAST_CRC_SRC  = 13'd45;
    localparam logic [12:0] CMD_LAST          = 13'd47;
    // Data frame layout: bits 0..7 token, 8..4103 payload (CRC16 covered), 4104..4119 CRC16.
    localparam logic [12:0] DATA_FIRST_COVERED = 13'd8;
    localparam logic [12:0] DATA_LAST_COVERED  = 13'd4103;
    localparam logic [12:0] DATA_LAST          = 13'd4119;

    // The bit currently on mosi is not kept here: sreg holds frame bits 1.. onward,
    // so sreg[4102] is always the bit that follows the one being transmitted.
    localparam int SREG_W = 4103;

    state_t              state;
    logic [SREG_W-1:0]   sreg;
    logic [12:0]         cnt;
    logic [15:0]         crc;

    logic [12:0]         cnt_inc;
    logic [6:0]          crc7_nxt;
    logic [15:0]         crc16_nxt;
    logic                sreg_next_bit;

    // One serial step of CRC7 (x^7 + x^3 + 1).
    function automatic logic [6:0] crc7_step(input logic [6:0] c, input logic b);
        logic fb;
        fb = b ^ c[6];
        return {c[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
    endfunction

    // One serial step of CRC16-CCITT (x^16 + x^12 + x^5 + 1).
    function automatic logic [15:0] crc16_step(input logic [15:0] c, input logic b);
        logic fb;
        fb = b ^ c[15];
        return {c[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
    endfunction

    // Next-value helpers shared by both frame types: counter increment, CRC updates
    // using the bit currently being transmitted, and the following payload bit.
    always_comb begin
        cnt_inc       = cnt + 13'd1;
        crc7_nxt      = crc7_step(crc[6:0], mosi);
        crc16_nxt     = crc16_step(crc, mosi);
        sreg_next_bit = sreg[SREG_W-1];
    end

    // Frame sequencer: loads the frame on acceptance, then on each bit_en strobe
    // retires the current bit, updates the CRC and presents the next bit.
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
            sreg  <= '0;
            cnt   <= '0;
            crc   <= '0;
            mosi  <= 1'b1;
            ready <= 1'b1;
            busy  <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    mosi <= 1'b1;
                    // A coincident bit_en is deliberately ignored so bit 0 gets a full slot.
                    if (valid && ready) begin
                        cnt   <= '0;
                        crc   <= '0;
                        ready <= 1'b0;
                        busy  <= 1'b1;
                        if (send_data) begin
                            // Token 0xFE: first bit 1 goes straight to mosi, remaining 7 lead sreg.
                            mosi  <= 1'b1;
                            sreg  <= {7'b1111110, data};
                            state <= SENDING_DATA;
                        end else begin
                            // Start bit 0 on mosi; transmission bit, index and argument follow.
                            mosi  <= 1'b0;
                            sreg  <= {1'b1, cmd_index, argument, {(SREG_W-39){1'b0}}};
                            state <= SENDING_CMD;
                        end
                    end
                end

                SENDING_CMD: begin
                    if (bit_en) begin
                        cnt  <= cnt_inc;
                        sreg <= {sreg[SREG_W-2:0], 1'b0};
                        if (cnt == CMD_LAST) begin
                            state <= IDLE;
                            mosi  <= 1'b1;
                            ready <= 1'b1;
                            busy  <= 1'b0;
                        end else if (cnt < CMD_LAST_COVERED) begin
                            crc[6:0] <= crc7_nxt;
                            mosi     <= sreg_next_bit;
                        end else if (cnt == CMD_LAST_COVERED) begin
                            // Final CRC value is known now; its MSB goes out with no gap.
                            crc[6:0] <= crc7_nxt;
                            mosi     <= crc7_nxt[6];
                        end else if (cnt <= CMD_LAST_CRC_SRC) begin
                            // CRC register shifts left; bit 5 becomes the next MSB on the wire.
                            crc[6:0] <= {crc[5:0], 1'b0};
                            mosi     <= crc[5];
                        end else begin
                            // End (stop) bit.
                            mosi <= 1'b1;
                        end
                    end
                end

                SENDING_DATA: begin
                    if (bit_en) begin
                        cnt  <= cnt_inc;
                        sreg <= {sreg[SREG_W-2:0], 1'b0};
                        if (cnt == DATA_LAST) begin
                            state <= IDLE;
                            mosi  <= 1'b1;
                            ready <= 1'b1;
                            busy  <= 1'b0;
                        end else if (cnt < DATA_LAST_COVERED) begin
                            // Token bits are shifted out but excluded from the CRC.
                            if (cnt >= DATA_FIRST_COVERED) begin
                                crc <= crc16_nxt;
                            end
                            mosi <= sreg_next_bit;
                        end else if (cnt == DATA_LAST_COVERED) begin
                            crc  <= crc16_nxt;
                            mosi <= crc16_nxt[15];
                        end else begin
                            crc  <= {crc[14:0], 1'b0};
                            mosi <= crc[14];
                        end
                    end
                end

                default: begin
                    state <= IDLE;
                    mosi  <= 1'b1;
                    ready <= 1'b1;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sd_sender.sv
// Self-checking bench for sd_sender: directed frames from the card protocol plus randomized frames and bit_en patterns.
// Expected frames come from a bit-list model with CRCs obtained by polynomial long division.
// Bit-level comparison is done every cycle, sampled on the falling clock edge.
module tb_sd_sender;

    logic          clock = 1'b0;
    logic          reset;
    logic          bit_en;
    logic          valid;
    logic          ready;
    logic          send_data;
    logic [5:0]    cmd_index;
    logic [31:0]   argument;
    logic [4095:0] data;
    logic          mosi;
    logic          busy;

    sd_sender dut (
        .clock     (clock),
        .reset     (reset),
        .bit_en    (bit_en),
        .valid     (valid),
        .ready     (ready),
        .send_data (send_data),
        .cmd_index (cmd_index),
        .argument  (argument),
        .data      (data),
        .mosi      (mosi),
        .busy      (busy)
    );

    always #5 clock = ~clock;

    int   n_checks = 0;
    int   n_fail   = 0;

    logic exp_bits [0:4119];
    int   exp_len;
    logic obs      [0:4119];
    logic msg      [0:4095];

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Remainder of msg[0..nbits-1] * x^deg divided by poly (coefficients poly[deg]..poly[0]).
    function automatic logic [15:0] polydiv(input int nbits, input int deg, input logic [16:0] poly);
        logic        wk [0:4111];
        logic [15:0] r;
        for (int i = 0; i < nbits + deg; i++) wk[i] = (i < nbits) ? msg[i] : 1'b0;
        for (int i = 0; i < nbits; i++) begin
            if (wk[i]) begin
                for (int j = 0; j <= deg; j++) wk[i+j] = wk[i+j] ^ poly[deg-j];
            end
        end
        r = '0;
        for (int j = 0; j < deg; j++) r = {r[14:0], wk[nbits+j]};
        return r;
    endfunction

    // Expected on-wire bit list for one request.
    task automatic build_frame(input logic sd, input logic [5:0] idx, input logic [31:0] arg,
                               input logic [4095:0] d);
        logic [39:0] m;
        logic [7:0]  tok;
        logic [15:0] c;
        if (!sd) begin
            m = {2'b01, idx, arg};
            for (int i = 0; i < 40; i++) begin
                msg[i]      = m[39-i];
                exp_bits[i] = m[39-i];
            end
            c = polydiv(40, 7, 17'h00089);
            for (int j = 0; j < 7; j++) exp_bits[40+j] = c[6-j];
            exp_bits[47] = 1'b1;
            exp_len = 48;
        end else begin
            tok = 8'hFE;
            for (int i = 0; i < 8; i++) exp_bits[i] = tok[7-i];
            for (int i = 0; i < 4096; i++) begin
                msg[i]        = d[4095-i];
                exp_bits[8+i] = d[4095-i];
            end
            c = polydiv(4096, 16, 17'h11021);
            for (int j = 0; j < 16; j++) exp_bits[4104+j] = c[15-j];
            exp_len = 4120;
        end
    endtask

    function automatic logic [63:0] obs_word(input int s, input int n);
        logic [63:0] r;
        r = '0;
        for (int i = 0; i < n; i++) r = {r[62:0], obs[s+i]};
        return r;
    endfunction

    task automatic rand_data(output logic [4095:0] d);
        for (int i = 0; i < 128; i++) d[i*32 +: 32] = $urandom;
    endtask

    // Present a request (called at a falling edge) and return at the falling edge after acceptance.
    task automatic issue(input logic sd, input logic [5:0] idx, input logic [31:0] arg,
                         input logic [4095:0] d);
        int waits;
        waits     = 0;
        send_data = sd;
        cmd_index = idx;
        argument  = arg;
        data      = d;
        valid     = 1'b1;
        bit_en    = 1'($urandom % 2);
        build_frame(sd, idx, arg, d);
        while (!ready && waits < 10000) begin
            @(posedge clock);
            @(negedge clock);
            waits++;
            bit_en = 1'($urandom % 2);
        end
        chk("accept_wait", 64'(waits), 64'd0);
        @(posedge clock);
        @(negedge clock);
    endtask

    // Drive bit_en and compare mosi every cycle against the expected frame.
    // mode: 0 random bit_en, 1 always high, n>1 every n-th cycle.
    task automatic stream(input string tag, input int mode, input int hold_low,
                          input logic hold_valid, input int abort_at);
        int             k;
        int             cyc;
        int             nerr;
        int             nbusy;
        logic           be;
        logic           first;
        logic [4095:0]  g;
        k = 0; cyc = 0; nerr = 0; nbusy = 0; first = 1'b1;
        valid = hold_valid;
        chk({tag, "_ready_lo"}, 64'(ready), 64'd0);
        chk({tag, "_busy_hi"}, 64'(busy), 64'd1);
        while (k < exp_len) begin
            if (first) obs[k] = mosi;
            if (mosi !== exp_bits[k]) nerr++;
            if (busy !== 1'b1 || ready !== 1'b0) nbusy++;
            if (k == abort_at) begin
                reset  = 1'b1;
                bit_en = 1'b0;
                @(posedge clock);
                @(negedge clock);
                chk({tag, "_prefix_bits"}, 64'(nerr), 64'd0);
                chk({tag, "_abort_mosi"}, 64'(mosi), 64'd1);
                chk({tag, "_abort_ready"}, 64'(ready), 64'd1);
                chk({tag, "_abort_busy"}, 64'(busy), 64'd0);
                reset = 1'b0;
                return;
            end
            if (k == 5 && first) begin
                // Scramble all request inputs mid-frame; the frame in flight must not change.
                send_data = 1'($urandom);
                cmd_index = 6'($urandom);
                argument  = $urandom;
                rand_data(g);
                data      = g;
            end
            if (cyc < hold_low)   be = 1'b0;
            else if (mode == 0)   be = 1'($urandom % 2);
            else if (mode == 1)   be = 1'b1;
            else                  be = ((cyc % mode) == mode - 1);
            bit_en = be;
            @(posedge clock);
            @(negedge clock);
            cyc++;
            first = be;
            if (be) k++;
            if (cyc > 40000) begin
                chk({tag, "_timeout"}, 64'(k), 64'(exp_len));
                break;
            end
        end
        bit_en = 1'b0;
        chk({tag, "_bits"}, 64'(nerr), 64'd0);
        chk({tag, "_busy_in_frame"}, 64'(nbusy), 64'd0);
        if (mode == 1 && hold_low == 0) chk({tag, "_cycles"}, 64'(cyc), 64'(exp_len));
        chk({tag, "_end_mosi"}, 64'(mosi), 64'd1);
        chk({tag, "_end_ready"}, 64'(ready), 64'd1);
        chk({tag, "_end_busy"}, 64'(busy), 64'd0);
    endtask

    initial begin
        logic [4095:0] d;
        logic [4095:0] ones;
        reset     = 1'b1;
        valid     = 1'b0;
        bit_en    = 1'b0;
        send_data = 1'b0;
        cmd_index = '0;
        argument  = '0;
        data      = '0;
        ones      = '1;
        repeat (3) @(posedge clock);
        @(negedge clock);
        chk("reset_ready", 64'(ready), 64'd1);
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_mosi", 64'(mosi), 64'd1);
        reset = 1'b0;
        // bit_en while idle does nothing.
        bit_en = 1'b1;
        repeat (3) @(negedge clock);
        chk("idle_bit_en_mosi", 64'(mosi), 64'd1);
        chk("idle_bit_en_ready", 64'(ready), 64'd1);
        bit_en = 1'b0;

        issue(1'b0, 6'd0, 32'h0, '0);
        stream("cmd0", 1, 0, 1'b0, -1);
        chk("cmd0_bytes", obs_word(0, 48), 64'h400000000095);

        issue(1'b0, 6'd8, 32'h000001AA, '0);
        stream("cmd8", 1, 0, 1'b0, -1);
        chk("cmd8_bytes", obs_word(0, 48), 64'h48000001AA87);

        issue(1'b0, 6'd8, 32'h000001AA, '0);
        stream("cmd8_div4", 4, 0, 1'b0, -1);
        chk("cmd8_div4_bytes", obs_word(0, 48), 64'h48000001AA87);

        issue(1'b1, 6'd0, 32'h0, ones);
        stream("blk_ff", 1, 0, 1'b0, -1);
        chk("blk_ff_token", obs_word(0, 8), 64'hFE);
        chk("blk_ff_crc", obs_word(4104, 16), 64'h7FA1);

        issue(1'b1, 6'd0, 32'h0, '0);
        stream("blk_zero", 1, 0, 1'b0, -1);
        chk("blk_zero_token", obs_word(0, 8), 64'hFE);
        chk("blk_zero_crc", obs_word(4104, 16), 64'h0000);

        // Back-to-back with valid held high: second request accepted on the idle cycle.
        issue(1'b0, 6'd17, $urandom, '0);
        stream("b2b_cmd17", 1, 0, 1'b1, -1);
        rand_data(d);
        issue(1'b1, 6'd0, 32'h0, d);
        stream("b2b_blk", 1, 0, 1'b0, -1);

        // Reset in the middle of a command, then a clean CMD0.
        issue(1'b0, 6'($urandom), $urandom, '0);
        stream("abort", 1, 0, 1'b0, 20);
        issue(1'b0, 6'd0, 32'h0, '0);
        stream("cmd0_after_rst", 1, 0, 1'b0, -1);
        chk("cmd0_after_rst_crc", obs_word(40, 8), 64'h95);

        // bit_en low for 100 cycles after acceptance.
        issue(1'b0, 6'd17, $urandom, '0);
        stream("hold_low", 1, 100, 1'b0, -1);

        // Randomized commands and one randomized block with random bit_en.
        for (int i = 0; i < 6; i++) begin
            issue(1'b0, 6'($urandom), $urandom, '0);
            stream("rnd_cmd", 0, 0, 1'b0, -1);
        end
        rand_data(d);
        issue(1'b1, 6'd0, 32'h0, d);
        stream("rnd_blk", 0, 0, 1'b0, -1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
